// File: rtl/burst_arbiter_if.sv
// Handshake bundle between the requesters, the burst arbiter and the downstream sink.
// The slave modport is the arbiter's view; the master modport is the requester/sink side.
interface burst_arbiter_if #(
  parameter int INPUTS = 4,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
);
  localparam int SRC_W = (INPUTS > 2) ? $clog2(INPUTS) : 1;

  logic [INPUTS-1:0]        req_valid;
  logic [INPUTS*DATA_W-1:0] req_data;
  logic [INPUTS*LEN_W-1:0]  req_len;
  logic [INPUTS-1:0]        req_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic                     out_last;
  logic [SRC_W-1:0]         out_src;
  logic                     out_ready;
  logic                     busy;

  modport slave (
    input  req_valid, req_data, req_len, out_ready,
    output req_ready, out_valid, out_data, out_last, out_src, busy
  );

  modport master (
    output req_valid, req_data, req_len, out_ready,
    input  req_ready, out_valid, out_data, out_last, out_src, busy
  );
endinterface

// File: rtl/burst_arbiter.sv
// Fixed-priority, non-preemptive burst arbiter: the lowest-index requester wins in IDLE
// and owns the output for req_len+1 beats, with one bubble cycle between bursts.
module burst_arbiter #(
  parameter int INPUTS = 4,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic           clk,
  input  logic           rst,
  burst_arbiter_if.slave bus
);
  localparam int SRC_W = (INPUTS > 2) ? $clog2(INPUTS) : 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [SRC_W-1:0]  owner_q, owner_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [DATA_W-1:0] data_arr [INPUTS];
  logic [LEN_W-1:0]  len_arr  [INPUTS];
  logic [SRC_W-1:0]  winner;
  logic              owner_valid;
  logic              xfer;
  logic              cnt_zero;

  logic [INPUTS-1:0] req_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;

  // unpack the flat per-requester buses
  always_comb begin
    for (int i = 0; i < INPUTS; i++) begin
      data_arr[i] = bus.req_data[i*DATA_W +: DATA_W];
      len_arr[i]  = bus.req_len[i*LEN_W +: LEN_W];
    end
  end

  // fixed priority: scanning downward leaves the lowest asserted index as winner
  always_comb begin
    winner = {SRC_W{1'b0}};
    for (int i = INPUTS - 1; i >= 0; i--) begin
      winner = bus.req_valid[i] ? SRC_W'(i) : winner;
    end
  end

  assign owner_valid = bus.req_valid[owner_q];
  assign cnt_zero    = (cnt_q == {LEN_W{1'b0}});
  assign xfer        = (state_q == BURST) && owner_valid && bus.out_ready;

  // state, owner, beat counter and held output data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= {SRC_W{1'b0}};
      cnt_q   <= {LEN_W{1'b0}};
      data_q  <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // next-state: arbitrate in IDLE, count beats in BURST
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          state_d = BURST;
          owner_d = winner;
          cnt_d   = len_arr[winner];
        end else begin
          state_d = IDLE;
        end
      end
      BURST: begin
        // out_data must hold whatever the last BURST cycle showed once we drop to IDLE
        data_d = data_arr[owner_q];
        if (xfer && cnt_zero) begin
          state_d = IDLE;
        end else if (xfer) begin
          cnt_d = cnt_q - LEN_W'(1'b1);
        end else begin
          state_d = BURST;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // outputs: the owner's lane is muxed through only while in BURST
  always_comb begin
    req_ready = {INPUTS{1'b0}};
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    out_data  = data_q;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
      end
      BURST: begin
        busy      = 1'b1;
        out_valid = owner_valid;
        out_last  = owner_valid && cnt_zero;
        out_data  = data_arr[owner_q];
        for (int i = 0; i < INPUTS; i++) begin
          req_ready[i] = (owner_q == SRC_W'(i)) && bus.out_ready;
        end
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign bus.req_ready = req_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_last  = out_last;
  assign bus.out_src   = owner_q;
  assign bus.busy      = busy;
endmodule

// File: tb/tb_burst_arbiter.sv
// Randomized bench for burst_arbiter: requester agents, a transaction-level reference
// model feeding a beat scoreboard, and a monitor checking every cycle.
module tb_burst_arbiter;
  localparam int INPUTS = 4;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;
  localparam int CYCLES = 4000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  burst_arbiter_if #(.INPUTS(INPUTS), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  burst_arbiter #(.INPUTS(INPUTS), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int src;
    int data;
    bit last;
  } beat_t;

  beat_t exp_q[$];
  int    tests = 0;
  int    fails = 0;
  int    bursts_seen = 0;
  int    resets_seen = 0;
  bit    done = 1'b0;

  // reference model: who owns the output and how many beats are still owed
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_left  = 0;
  int m_data  = 0;

  // expectations for the current cycle
  bit e_busy, e_valid, e_last;
  int e_src, e_ready, e_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // model evaluates this cycle's outputs, then applies the upcoming clock edge
  always @(negedge clk) begin
    int win;
    bit beat;
    win     = -1;
    e_busy  = m_busy;
    e_src   = m_owner;
    e_valid = m_busy && bus.req_valid[m_owner];
    e_ready = (m_busy && bus.out_ready) ? (1 << m_owner) : 0;
    e_last  = e_valid && (m_left == 1);
    e_data  = m_busy ? int'(bus.req_data[m_owner*DATA_W +: DATA_W]) : m_data;
    beat    = e_valid && bus.out_ready;
    if (beat) exp_q.push_back('{m_owner, e_data, (m_left == 1)});
    if (m_busy) m_data = e_data;
    if (rst) begin
      m_busy = 1'b0; m_owner = 0; m_left = 0; m_data = 0;
    end else if (!m_busy) begin
      for (int i = INPUTS - 1; i >= 0; i--) if (bus.req_valid[i]) win = i;
      if (win >= 0) begin
        m_busy  = 1'b1;
        m_owner = win;
        m_left  = int'(bus.req_len[win*LEN_W +: LEN_W]) + 1;
      end
    end else if (beat) begin
      m_left--;
      if (m_left == 0) m_busy = 1'b0;
    end
  end

  // monitor: per-cycle output checks plus scoreboard pop on every transfer
  always @(negedge clk) begin
    beat_t b;
    #1;
    if (!done) begin
      chk("busy",      32'(bus.busy),      32'(e_busy));
      chk("out_valid", 32'(bus.out_valid), 32'(e_valid));
      chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
      chk("out_src",   32'(bus.out_src),   32'(e_src));
      chk("out_last",  32'(bus.out_last),  32'(e_last));
      chk("out_data",  32'(bus.out_data),  32'(e_data));
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL beat_unexpected: got src %0d data %0h, expected no beat at t=%0t",
                   bus.out_src, bus.out_data, $time);
        end else begin
          b = exp_q.pop_front();
          chk("beat_src",  32'(bus.out_src),  32'(b.src));
          chk("beat_data", 32'(bus.out_data), 32'(b.data));
          chk("beat_last", 32'(bus.out_last), 32'(b.last));
          if (b.last) bursts_seen++;
        end
      end
      if (exp_q.size() != 0) begin
        tests++; fails++;
        $display("FAIL beat_missing: got no transfer, expected %0d beat(s) at t=%0t",
                 exp_q.size(), $time);
        exp_q.delete();
      end
    end
  end

  // requester agents: each walks through its own bursts of alen+1 beats
  bit                pend [INPUTS];
  int                alen [INPUTS];
  int                ak   [INPUTS];
  int                aseq [INPUTS];
  logic [INPUTS-1:0] hs;

  initial begin
    int r;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_len   = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < INPUTS; i++) begin
      pend[i] = 1'b0; alen[i] = 0; ak[i] = 0; aseq[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(negedge clk);
      hs = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      if (rst) begin
        resets_seen++;
        for (int i = 0; i < INPUTS; i++) pend[i] = 1'b0;
      end else begin
        for (int i = 0; i < INPUTS; i++) begin
          if (hs[i]) begin
            ak[i]++;
            if (ak[i] > alen[i]) pend[i] = 1'b0;
          end
        end
      end
      rst = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < INPUTS; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          ak[i]   = 0;
          aseq[i]++;
          r = $urandom_range(0, 9);
          alen[i] = (r < 2) ? 0 : (r < 4) ? 15 : $urandom_range(0, 15);
        end
        bus.req_valid[i] = pend[i] && ($urandom_range(0, 5) != 0);
        bus.req_data[i*DATA_W +: DATA_W] = pend[i] ? 8'(i*64 + (aseq[i] % 4)*16 + ak[i])
                                                   : 8'($urandom);
        // length is only meaningful until the first beat moves; scramble it afterwards
        bus.req_len[i*LEN_W +: LEN_W] = (pend[i] && ak[i] == 0) ? 4'(alen[i])
                                                                : 4'($urandom_range(0, 15));
      end
      bus.out_ready = ($urandom_range(0, 9) < 7);
    end
    done = 1'b1;
    tests++;
    if (bursts_seen < 30) begin
      fails++;
      $display("FAIL burst_count: got %0d completed bursts, expected at least 30", bursts_seen);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/burst_arbiter.md
BURST_ARBITER -- requirements
Module: burst_arbiter

Interface
REQ-001 Parameter INPUTS, default 4, number of requesters (>=2); index 0 is highest priority.
REQ-002 Parameter DATA_W, default 8, beat data width.
REQ-003 Parameter LEN_W, default 4, burst length field width; the field encodes beats minus 1.
REQ-004 Localparam SRC_W = max(1, clog2(INPUTS)), requester index width.
REQ-005 The block has one clock and its reset is synchronous and active-high.
REQ-006 clk  input  1  the single clock; all state updates on the rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 req_valid  input  INPUTS  per-requester beat valid; also serves as the arbitration request.
REQ-009 req_data  input  INPUTS*DATA_W  per-requester beat data; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-010 req_len  input  INPUTS*LEN_W  per-requester burst length minus 1; requester i occupies bits [i*LEN_W +: LEN_W].
REQ-011 req_ready  output  INPUTS  per-requester beat accept.
REQ-012 out_valid  output  1  downstream beat valid.
REQ-013 out_data  output  DATA_W  downstream beat data.
REQ-014 out_last  output  1  marks the final beat of the burst.
REQ-015 out_src  output  SRC_W  index of the current owner.
REQ-016 out_ready  input  1  downstream beat accept.
REQ-017 busy  output  1  high while a burst is owned.

Function
REQ-018 Two states: IDLE and BURST.
REQ-019 IDLE behaviour:
  - req_ready = 0, out_valid = 0, out_last = 0, busy = 0.
  - out_src and out_data hold their last values (0 after reset).
REQ-020 IDLE arbitration:
  - Fixed priority, lowest asserted index of req_valid wins.
  - The winner is registered into the owner register.
  - req_len of the winner is registered into the beat counter.
  - The state moves to BURST on the next edge.
  - No beat transfers in the arbitration cycle (one-cycle grant latency).
REQ-021 IDLE with req_valid == 0: remain in IDLE; owner and counter are unchanged.
REQ-022 BURST outputs:
  - busy = 1, out_src = owner.
  - out_valid = req_valid[owner], out_data = req_data[owner].
  - req_ready[owner] = out_ready; every other req_ready bit = 0.
REQ-023 BURST: out_last = out_valid AND (beat counter == 0).
REQ-024 A beat transfers when out_valid AND out_ready are both high in BURST.
  - On a non-final transfer, the counter decrements by 1.
REQ-025 Final-beat transfer (counter == 0): the state returns to IDLE on the next edge.
  - Re-arbitration happens in that IDLE cycle, so there is one bubble cycle between bursts.
REQ-026 BURST with out_valid low or out_ready low: state, owner and counter hold; no timeout.
  - The grant stays locked even if the owner drops req_valid.
REQ-027 Changes to req_len or to other requesters' req_valid during BURST are ignored until the next IDLE.
REQ-028 Preemption: none; a higher-priority request waits until the current burst completes.
REQ-029 Length range: req_len = 0 gives a 1-beat burst; all-ones gives a 2^LEN_W-beat burst.
  - The counter never wraps below 0.
REQ-030 Total beats per burst is exactly req_len(at grant) + 1.
REQ-031 The outputs are combinational from state, owner, counter, req_* and out_ready.
  - There is no combinational path from out_ready to out_valid.

Reset
REQ-032 rst sampled high at a clock edge forces:
  - state = IDLE, owner = 0, counter = 0.
  - Outputs then read req_ready = 0, out_valid = 0, out_last = 0, busy = 0, out_src = 0.
  - out_data is treated as don't-care while out_valid = 0.
REQ-033 Reset mid-burst aborts the burst without a final beat; the next grant follows normal IDLE arbitration.
REQ-034 rst has priority over every other event in the same cycle.

Verification
REQ-035 Single burst:
  - Stimulus: req_valid = 4'b0100, req_len[2] = 2, out_ready = 1, data 0xA0, 0xA1, 0xA2.
  - Response: idle cycle; then 3 beats with out_src = 2; out_last only on 0xA2; busy falls after the third beat; req_ready = 4'b0100 during the burst.
REQ-036 Simultaneous requests:
  - Stimulus: req_valid = 4'b1010, both len = 0.
  - Response: requester 1 is granted first (1 beat), then one bubble cycle, then requester 3 (1 beat).
REQ-037 Backpressure:
  - Stimulus: len = 3; out_ready toggles 1, 0, 0, 1, ...
  - Response: exactly 4 transfers; the counter holds while out_ready = 0; out_last is asserted continuously while the final beat stalls.
REQ-038 No preemption:
  - Stimulus: requester 2 owns a 4-beat burst; req_valid[0] rises after beat 1.
  - Response: out_src stays 2 until the last beat; requester 0 is granted in the following IDLE cycle.
REQ-039 Owner gap:
  - Stimulus: the owner drops req_valid for 3 cycles mid-burst while requester 0 is valid.
  - Response: out_valid = 0, busy = 1, out_src unchanged, req_ready[0] = 0; the burst resumes intact.
REQ-040 Reset mid-burst:
  - Stimulus: rst high after beat 2 of 5.
  - Response: the next cycle shows busy = 0, out_valid = 0, out_src = 0; a later request restarts with its full length.
